// File: rtl/morse_pkg.sv
// Shared definitions for the Morse transmit sequencer.
//   state_e   : sequencer states
//   *_UNITS   : durations of each element and gap, in Morse units
//   MAX_LEN   : maximum number of elements in one character
//   clamp_len : limits a requested element count to the supported maximum
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    ELEM_GAP,
    CHAR_GAP,
    WORD_GAP
  } state_e;

  localparam logic [2:0] DOT_UNITS      = 3'd1;
  localparam logic [2:0] DASH_UNITS     = 3'd3;
  localparam logic [2:0] ELEM_GAP_UNITS = 3'd1;
  localparam logic [2:0] CHAR_GAP_UNITS = 3'd3;
  localparam logic [2:0] WORD_GAP_UNITS = 3'd7;
  localparam int         MAX_LEN        = 5;

  function automatic logic [2:0] clamp_len(input logic [2:0] len, input logic [2:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Prescaler producing one tick per Morse unit.
//   clk    : system clock
//   rst    : asynchronous active-low reset
//   clr_i  : synchronous clear; restarts the unit at count 0 on the next edge
//   tick_o : high for the one cycle in which the count is at its terminal value
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int            CW   = $clog2(UNIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(UNIT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (clr_i || cnt_q == LAST) cnt_d = '0;
    else                        cnt_d = cnt_q + 1'b1;
  end

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/morse_tx_sequencer.sv
// Keys one Morse character at a time: marks for dots/dashes, then element,
// character or word gaps, all timed in units of UNIT_CYCLES clocks.
//   clk       : 100 MHz system clock
//   rst       : asynchronous active-low reset
//   sym_valid : character request
//   sym_ready : high in IDLE (low while in reset); accept = sym_valid && sym_ready
//   sym_len   : element count 0..5 (0 = word space, >5 clamped to 5)
//   sym_bits  : element types, bit0 first; 1 = dash, 0 = dot
//   abort     : synchronous cancel back to IDLE, no sym_done
//   key_out   : registered key, high during marks
//   busy      : high whenever not IDLE
//   sym_done  : one-cycle pulse when a character and its trailing gap complete
module morse_tx_sequencer #(
  parameter int UNIT_CYCLES = 50_000_000,
  parameter int MAX_LEN     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sym_valid,
  output logic       sym_ready,
  input  logic [2:0] sym_len,
  input  logic [4:0] sym_bits,
  input  logic       abort,
  output logic       key_out,
  output logic       busy,
  output logic       sym_done
);

  import morse_pkg::*;

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] unit_q, unit_d;
  logic [2:0] len_q, len_d;
  logic [4:0] bits_q, bits_d;
  logic       key_q, key_d;
  logic       done_q, done_d;

  logic       tick;
  logic       timer_clr;
  logic       accept;
  logic [2:0] need_units;
  logic       last_unit;

  morse_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (timer_clr),
    .tick_o(tick)
  );

  // Gated by rst so the source sees no readiness while the block is held in reset.
  assign sym_ready = (state_q == IDLE) && rst;
  assign accept    = sym_valid && sym_ready && !abort;

  always_comb begin
    case (state_q)
      MARK:     need_units = bits_q[idx_q] ? DASH_UNITS : DOT_UNITS;
      ELEM_GAP: need_units = ELEM_GAP_UNITS;
      CHAR_GAP: need_units = CHAR_GAP_UNITS;
      WORD_GAP: need_units = WORD_GAP_UNITS;
      default:  need_units = DOT_UNITS;
    endcase
  end

  assign last_unit = tick && (unit_q == need_units - 3'd1);

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    bits_d  = bits_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          len_d   = clamp_len(sym_len, 3'(MAX_LEN));
          bits_d  = sym_bits;
          idx_d   = 3'd0;
          state_d = (sym_len == 3'd0) ? WORD_GAP : MARK;
        end
      end
      MARK: begin
        if (last_unit) begin
          if (idx_q == len_q - 3'd1) begin
            state_d = CHAR_GAP;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ELEM_GAP;
          end
        end
      end
      ELEM_GAP: begin
        if (last_unit) state_d = MARK;
      end
      CHAR_GAP, WORD_GAP: begin
        if (last_unit) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      idx_d   = 3'd0;
      done_d  = 1'b0;
    end
  end

  // The unit timer idles at 0 in IDLE and restarts on every state change,
  // so each element and gap begins on a fresh unit boundary.
  assign timer_clr = (state_d != state_q) || (state_q == IDLE) || abort;

  always_comb begin
    if (state_d != state_q || state_q == IDLE || abort) unit_d = 3'd0;
    else if (tick)                                      unit_d = unit_q + 3'd1;
    else                                                unit_d = unit_q;
  end

  // Outputs are registered from the next state so key_out is glitch-free.
  assign key_d = (state_d == MARK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      unit_q  <= 3'd0;
      len_q   <= 3'd0;
      bits_q  <= 5'd0;
      key_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      unit_q  <= unit_d;
      len_q   <= len_d;
      bits_q  <= bits_d;
      key_q   <= key_d;
      done_q  <= done_d;
    end
  end

  assign key_out  = key_q;
  assign sym_done = done_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_morse_tx_sequencer.sv
// Self-checking bench for morse_tx_sequencer with a 4-cycle unit.
module tb_morse_tx_sequencer;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       sym_valid;
  logic       sym_ready;
  logic [2:0] sym_len;
  logic [4:0] sym_bits;
  logic       abort;
  logic       key_out;
  logic       busy;
  logic       sym_done;

  morse_tx_sequencer #(
    .UNIT_CYCLES(U),
    .MAX_LEN    (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sym_valid(sym_valid),
    .sym_ready(sym_ready),
    .sym_len  (sym_len),
    .sym_bits (sym_bits),
    .abort    (abort),
    .key_out  (key_out),
    .busy     (busy),
    .sym_done (sym_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: expected key level for each remaining busy cycle of the
  // current character; an empty queue means the sequencer is idle.
  bit exp_q[$];
  bit done_exp = 1'b0;

  typedef struct {
    string      name;
    logic [2:0] len;
    logic [4:0] bits;
    int         busy_cycles;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_char(input logic [2:0] l, input logic [4:0] b);
    int n;
    n = (l > 3'd5) ? 5 : int'(l);
    exp_q.delete();
    if (n == 0) begin
      repeat (7 * U) exp_q.push_back(1'b0);
    end else begin
      for (int i = 0; i < n; i++) begin
        repeat ((b[i] ? 3 : 1) * U) exp_q.push_back(1'b1);
        repeat (((i == n - 1) ? 3 : 1) * U) exp_q.push_back(1'b0);
      end
    end
  endtask

  task automatic check_outputs();
    bit exp_busy;
    exp_busy = (exp_q.size() != 0);
    check("busy", busy, exp_busy);
    check("key_out", key_out, exp_busy ? exp_q[0] : 1'b0);
    check("sym_ready", sym_ready, !exp_busy);
    check("sym_done", sym_done, done_exp);
  endtask

  // Drive inputs for one cycle, advance the model across the coming edge,
  // then compare every output at the following falling edge.
  task automatic step(input bit v, input logic [2:0] l, input logic [4:0] b, input bit ab);
    sym_valid = v;
    sym_len   = l;
    sym_bits  = b;
    abort     = ab;
    if (ab) begin
      exp_q.delete();
      done_exp = 1'b0;
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      done_exp = (exp_q.size() == 0);
    end else if (v) begin
      load_char(l, b);
      done_exp = 1'b0;
    end else begin
      done_exp = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_step();
    step(1'b0, 3'd0, 5'd0, 1'b0);
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;

    vecs[0] = '{"A",        3'd2, 5'b00010, 32};
    vecs[1] = '{"word",     3'd0, 5'b10101, 28};
    vecs[2] = '{"E",        3'd1, 5'b00000, 16};
    vecs[3] = '{"T",        3'd1, 5'b00001, 24};
    vecs[4] = '{"clamp7",   3'd7, 5'b11111, 88};
    vecs[5] = '{"five_dot", 3'd5, 5'b00000, 48};
    vecs[6] = '{"ign_bits", 3'd2, 5'b11100, 24};

    rst       = 1'b0;
    sym_valid = 1'b0;
    sym_len   = 3'd0;
    sym_bits  = 5'd0;
    abort     = 1'b0;

    #2;
    check("rst_key_out", key_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sym_done", sym_done, 1'b0);
    check("rst_sym_ready", sym_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_ready", sym_ready, 1'b1);

    // Table: each character's busy length, plus full per-cycle model checks.
    foreach (vecs[k]) begin
      step(1'b1, vecs[k].len, vecs[k].bits, 1'b0);
      busy_cnt = 0;
      while (busy && busy_cnt < 200) begin
        busy_cnt++;
        idle_step();
      end
      check({"busy_len_", vecs[k].name}, busy_cnt, vecs[k].busy_cycles);
      check({"done_end_", vecs[k].name}, sym_done, 1'b1);
    end
    idle_step();

    // Back-to-back "E" with sym_valid held: second accept on the done cycle.
    done_cnt = 0;
    for (int c = 0; c < 34; c++) begin
      step(1'b1, 3'd1, 5'd0, 1'b0);
      if (sym_done) done_cnt++;
    end
    check("b2b_done_pulses", done_cnt, 2);
    repeat (3) idle_step();

    // Abort during the dash of "A": idle on the next cycle, no sym_done.
    step(1'b1, 3'd2, 5'b00010, 1'b0);
    repeat (10) idle_step();
    check("abort_pre_key", key_out, 1'b1);
    step(1'b0, 3'd0, 5'd0, 1'b1);
    check("abort_key", key_out, 1'b0);
    check("abort_ready", sym_ready, 1'b1);
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      idle_step();
      if (sym_done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);

    // Abort coincident with a request in IDLE: nothing is accepted.
    step(1'b1, 3'd2, 5'b00010, 1'b1);
    check("abort_idle_busy", busy, 1'b0);
    idle_step();

    // Asynchronous reset in the middle of a dash.
    step(1'b1, 3'd1, 5'b00001, 1'b0);
    repeat (5) idle_step();
    check("pre_arst_key", key_out, 1'b1);
    #1 rst = 1'b0;
    #1;
    check("arst_key", key_out, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_done", sym_done, 1'b0);
    @(negedge clk);
    exp_q.delete();
    done_exp = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_release_ready", sym_ready, 1'b1);
    step(1'b1, 3'd1, 5'd0, 1'b0);
    for (int c = 0; c < 18; c++) idle_step();

    // Randomized traffic against the model, with occasional aborts.
    for (int c = 0; c < 2500; c++) begin
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
           5'($urandom_range(0, 31)), $urandom_range(0, 199) == 0);
    end
    repeat (100) idle_step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_tx_sequencer.md
# morse_tx_sequencer

Sequences on-off keying for one Morse character at a time, timing dots, dashes and gaps from a programmable unit period derived from the 100 MHz system clock. It sits between the character source (text/lookup logic) and the key output driving the LED/buzzer. It uses the same free-running-prescaler style of timebase as the existing seconds counter, but owns its own unit timer so that each symbol starts phase-aligned.

## Interface
- UNIT_CYCLES, 50_000_000, clock cycles per Morse unit (0.5 s at 100 MHz); must be ≥ 2
- MAX_LEN, 5, maximum elements per character
- clk  input  1  100 MHz system clock
- rst  input  1  reset; one clock; reset is asynchronous and active-low
- sym_valid  input  1  character request
- sym_ready  output  1  high only in IDLE; a character is accepted on a clk edge where sym_valid && sym_ready
- sym_len  input  3  element count, 0..5; 0 = word space; values >5 are clamped to 5
- sym_bits  input  5  element types, bit0 sent first; 1 = dash, 0 = dot
- abort  input  1  synchronous cancel, highest priority after reset
- key_out  output  1  registered key signal, high during marks
- busy  output  1  high whenever the state is not IDLE
- sym_done  output  1  one-cycle pulse when a character (including its trailing gap) completes

## Operation
- States: IDLE, MARK, ELEM_GAP, CHAR_GAP, WORD_GAP.
- IDLE: sym_ready=1. On accept, latch len (clamped) and bits, clear element index and unit timer; go to MARK if len≥1, else WORD_GAP.
- MARK: key_out=1 for 1 unit (dot) or 3 units (dash) per sym_bits[idx]. At end: if idx==len-1 go to CHAR_GAP, else idx++ and go to ELEM_GAP.
- ELEM_GAP: key_out=0 for 1 unit, then MARK.
- CHAR_GAP: key_out=0 for 3 units, then IDLE with sym_done pulse.
- WORD_GAP: key_out=0 for 7 units, then IDLE with sym_done pulse.
- Unit timer: counts 0..UNIT_CYCLES-1, issues unit tick on terminal count; unit counter counts ticks within a state (3 bits, max 7) and clears on every state change.
- abort (any state): next state IDLE, key_out=0, timers cleared, no sym_done. abort in IDLE is a no-op; abort has priority over a simultaneous accept (no accept that cycle).
- Reset values: key_out=0, busy=0, sym_done=0, sym_ready=1 after rst deasserts (sym_ready=0 while rst is asserted), state IDLE, all counters 0.
- sym_bits bits at index ≥ len are ignored.

## Timing
- Let accept occur on edge E0. key_out first reflects the first mark in the cycle after E0; a dot lasts exactly UNIT_CYCLES cycles, a dash 3×UNIT_CYCLES.
- Total busy time of a character = UNIT_CYCLES × (Σ element units + (len−1) + 3); word space = 7×UNIT_CYCLES.
- sym_done and sym_ready rise in the same cycle; a new character may be accepted on that cycle's edge (back-to-back, no extra gap because CHAR_GAP is already included).
- sym_valid held high while busy is ignored until sym_ready.
- Async reset mid-character: key_out drops immediately, with no sym_done.

## Structure
- Package morse_pkg: state enum; constants DOT_UNITS=1, DASH_UNITS=3, ELEM_GAP_UNITS=1, CHAR_GAP_UNITS=3, WORD_GAP_UNITS=7, MAX_LEN=5.
- Sub-module morse_unit_timer: prescaler with synchronous clear input and a one-cycle tick output; width $clog2(UNIT_CYCLES).
- Top: FSM, element index, unit counter, registered outputs.

## Test plan (UNIT_CYCLES=4)
- Reset, then accept "A" (len=2, bits=5'b00010) -> key_out high for 4 cycles, low for 4, high for 12, low for 12; sym_done in the 33rd cycle after accept; sym_ready returns in that same cycle.
- Word space (len=0) -> key_out stays 0, busy for 28 cycles, then a single sym_done pulse.
- Back-to-back "E" (len=1, bits=0) twice with sym_valid held high -> second accept on the sym_done cycle; key_out pattern 4 high, 12 low, 4 high, 12 low.
- sym_len=7, bits=5'b11111 -> five dashes (clamped to 5); total busy time 4×(15+4+3)=88 cycles.
- abort during the second element of "A" -> key_out low next cycle; IDLE/sym_ready next cycle; no sym_done; abort coincident with sym_valid in IDLE -> no accept.
- Assert rst asynchronously mid-dash -> key_out=0 and busy=0 without waiting for clk; after release, normal accept works.
